// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared opcode, flag-index and helper definitions for the ALU command front end.
package alu_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NOT  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_LESS = 3'b110,
    OP_EQ   = 3'b111
  } alu_op_e;

  localparam int FLAG_W    = 5;
  localparam int FLG_LESS  = 0;
  localparam int FLG_EQ    = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_CARRY = 3;
  localparam int FLG_OVF   = 4;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic ovf, input logic carry,
                                                   input logic zero, input logic equal,
                                                   input logic less);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLG_OVF]   = ovf;
    f[FLG_CARRY] = carry;
    f[FLG_ZERO]  = zero;
    f[FLG_EQ]    = equal;
    f[FLG_LESS]  = less;
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Command and response handshake bundle between a requester and alu_cmd_ctrl.
interface alu_cmd_ctrl_if
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opt;
  logic [W-1:0]      cmd_a;
  logic [W-1:0]      cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [FLAG_W-1:0] rsp_flags;

  modport master (
    output cmd_valid, cmd_opt, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_opt, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with occupancy count; head is read combinationally from storage.
module alu_cmd_fifo
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Buffers ALU commands, drives the external ALU from the FIFO head and captures its result.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_ctrl_if.slave     bus,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_opt,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_less,
  input  logic              alu_equal,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr,
  output logic [CNT_W-1:0]  done_cnt
);
  localparam int DW = 3 + 2 * W;

  logic [DW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              cap;
  logic              rsp_take;
  logic [FLAG_W-1:0] new_flags;

  assign push          = bus.cmd_valid && !full;
  assign cap           = !empty && (!bus.rsp_valid || bus.rsp_ready);
  assign rsp_take      = bus.rsp_valid && bus.rsp_ready;
  assign bus.cmd_ready = !full;
  assign {alu_opt, alu_a, alu_b} = empty ? '0 : head;
  assign new_flags     = pack_flags(alu_overflow, alu_carry, alu_zero, alu_equal, alu_less);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (cap),
    .din   ({bus.cmd_opt, bus.cmd_a, bus.cmd_b}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      sticky_flags   <= '0;
      done_cnt       <= '0;
    end else begin
      if (cap) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_result <= alu_result;
        bus.rsp_flags  <= new_flags;
      end else if (rsp_take) begin
        bus.rsp_valid  <= 1'b0;
      end
      if (rsp_take) done_cnt <= done_cnt + CNT_W'(1);
      // A clear coinciding with a capture leaves exactly the new flags.
      sticky_flags <= (sticky_clr ? '0 : sticky_flags) | (cap ? new_flags : '0);
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural 4-bit signed ALU on the operand pins.
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sticky_clr = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opt;
  logic       alu_less, alu_equal, alu_carry, alu_overflow, alu_zero;
  logic [4:0] sticky_flags;
  logic [7:0] done_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [8:0]  sb_q[$];

  alu_cmd_ctrl_if #(.W(4)) bus ();

  alu_cmd_ctrl #(.DEPTH(2), .W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opt      (alu_opt),
    .alu_result   (alu_result),
    .alu_less     (alu_less),
    .alu_equal    (alu_equal),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .done_cnt     (done_cnt)
  );

  always #5 clk = ~clk;

  // Compare ops return a-b with its carry; zero is reported for arithmetic/logic ops only.
  logic [4:0] sum;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
    alu_result = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
    alu_zero = 1'b0; alu_less = 1'b0; alu_equal = 1'b0;
    case (alu_opt)
      OP_ADD: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[3:0]; alu_carry = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
        alu_zero = (sum[3:0] == 4'd0);
      end
      OP_SUB: begin
        alu_result = sum[3:0]; alu_carry = sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
        alu_zero = (sum[3:0] == 4'd0);
      end
      OP_NOT: begin alu_result = ~alu_a;         alu_zero = (alu_result == 4'd0); end
      OP_AND: begin alu_result = alu_a & alu_b;  alu_zero = (alu_result == 4'd0); end
      OP_OR:  begin alu_result = alu_a | alu_b;  alu_zero = (alu_result == 4'd0); end
      OP_XOR: begin alu_result = alu_a ^ alu_b;  alu_zero = (alu_result == 4'd0); end
      OP_LESS: begin
        alu_result = sum[3:0]; alu_carry = sum[4];
        alu_less = ($signed(alu_a) < $signed(alu_b));
      end
      default: begin
        alu_result = sum[3:0]; alu_carry = sum[4];
        alu_equal = (alu_a == alu_b);
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] er, input logic [4:0] ef);
    int unsigned n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_opt = op; bus.cmd_a = a; bus.cmd_b = b;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1 at %0t", $time);
    end else begin
      sb_q.push_back({er, ef});
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb_q.size() != 0 || bus.rsp_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", sb_q.size(), 0);
  endtask

  // Monitor: pops on every accepted response and checks stalled responses hold steady.
  logic       held_v = 1'b0;
  logic [8:0] held;
  logic [8:0] exp_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (bus.rsp_valid && held_v) chk("rsp_stable", {bus.rsp_result, bus.rsp_flags}, held);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got result %0h flags %b expected none",
                   bus.rsp_result, bus.rsp_flags);
        end else begin
          exp_r = sb_q.pop_front();
          chk("rsp_result", bus.rsp_result, exp_r[8:5]);
          chk("rsp_flags", bus.rsp_flags, exp_r[4:0]);
        end
        held_v = 1'b0;
      end else if (bus.rsp_valid) begin
        held_v = 1'b1;
        held = {bus.rsp_result, bus.rsp_flags};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_opt = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    #3;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_alu_pins", {alu_opt, alu_a, alu_b}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow with latency check, then sticky accumulation and clear-on-capture
    bus.rsp_ready = 1'b1;
    push(OP_ADD, 4'b0111, 4'b0001, 4'b1000, 5'b10000);
    chk("lat_valid_low", bus.rsp_valid, 0);
    chk("head_pins", {alu_opt, alu_a, alu_b}, {3'b000, 4'b0111, 4'b0001});
    @(posedge clk); #1;
    chk("lat_valid_high", bus.rsp_valid, 1);
    chk("sticky_ovf", sticky_flags, 5'b10000);
    push(OP_XOR, 4'b0000, 4'b0000, 4'b0000, 5'b00100);
    @(posedge clk); #1;
    chk("sticky_or", sticky_flags, 5'b10100);
    push(OP_SUB, 4'b0011, 4'b0011, 4'b0000, 5'b01100);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("sticky_clr_cap", sticky_flags, 5'b01100);
    drain();
    chk("done_3", done_cnt, 3);

    // Reset mid-stream with a stalled response and a queued command
    bus.rsp_ready = 1'b0;
    push(OP_ADD, 4'b0111, 4'b0001, 4'b1000, 5'b10000);
    push(OP_SUB, 4'b0011, 4'b0011, 4'b0000, 5'b01100);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", bus.rsp_valid, 0);
    chk("mrst_rsp_data", {bus.rsp_result, bus.rsp_flags}, 0);
    chk("mrst_sticky", sticky_flags, 0);
    chk("mrst_done", done_cnt, 0);
    chk("mrst_alu_pins", {alu_opt, alu_a, alu_b}, 0);
    sb_q.delete();
    #1 rst_n = 1'b1;
    chk("mrst_cmd_ready", bus.cmd_ready, 1);
    bus.rsp_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_rsp", bus.rsp_valid, 0);
    end

    // Back-to-back directed vectors at full throughput
    push(OP_EQ,   4'b0011, 4'b0011, 4'b0000, 5'b01010);
    push(OP_LESS, 4'b1110, 4'b0001, 4'b1101, 5'b01001);
    push(OP_AND,  4'b1100, 4'b1010, 4'b1000, 5'b00000);
    push(OP_OR,   4'b0000, 4'b0000, 4'b0000, 5'b00100);
    push(OP_NOT,  4'b0101, 4'b0000, 4'b1010, 5'b00000);
    push(OP_SUB,  4'b1000, 4'b0001, 4'b0111, 5'b11000);
    push(OP_ADD,  4'b1111, 4'b0001, 4'b0000, 5'b01100);
    drain();
    chk("done_7", done_cnt, 7);

    // Backpressure: fill FIFO behind a stalled response, fourth command waits
    bus.rsp_ready = 1'b0;
    push(OP_ADD, 4'b0010, 4'b0011, 4'b0101, 5'b00000);
    push(OP_SUB, 4'b0101, 4'b0010, 4'b0011, 5'b01000);
    push(OP_XOR, 4'b1111, 4'b1010, 4'b0101, 5'b00000);
    chk("full_cmd_ready", bus.cmd_ready, 0);
    fork
      push(OP_EQ, 4'b0001, 4'b0010, 4'b1111, 5'b00000);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_held", bus.cmd_ready, 0);
        chk("stall_head_rsp", bus.rsp_result, 4'b0101);
        bus.rsp_ready = 1'b1;
      end
    join
    drain();
    chk("done_11", done_cnt, 11);

    // Counter wrap after 256 accepted responses
    for (int unsigned i = 0; i < 245; i++) push(OP_ADD, 4'b0000, 4'b0000, 4'b0000, 5'b00100);
    drain();
    chk("done_wrap", done_cnt, 0);
    push(OP_OR, 4'b0001, 4'b0100, 4'b0101, 5'b00000);
    drain();
    chk("done_after_wrap", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
